// File: rtl/keypad_digit_ctrl.sv
// Decimal keypad front end: synchronizes and debounces ten one-hot key lines,
// accumulates up to four BCD digits and offers the number over valid/ready.
module keypad_digit_ctrl #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DB_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  key,
  input  logic        clr,
  input  logic        enter,
  output logic [15:0] num,
  output logic [2:0]  cnt,
  output logic [3:0]  digit,
  output logic        digit_vld,
  output logic        num_vld,
  input  logic        num_rdy,
  output logic        err
);

  localparam int unsigned KEY_W  = 10;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned NUM_W  = 16;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_REL_DB,
    S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_W-1:0]    sync1_q, ks_q;
  logic [KEY_W-1:0]    oh_q, oh_d;
  logic [DB_W-1:0]     dbc_q, dbc_d;
  logic [NUM_W-1:0]    num_q, num_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   digit_q, digit_d;
  logic                digit_vld_q, digit_vld_d;
  logic                num_vld_q, num_vld_d;
  logic                err_q, err_d;

  logic                any_c, one_hot_c, multi_c, db_done_c;
  logic [DB_W-1:0]     dbc_inc_c;
  logic [CODE_W-1:0]   code_c;

  function automatic logic [CODE_W-1:0] enc(input logic [KEY_W-1:0] oh);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (oh[i]) c = CODE_W'(i);
    end
    return c;
  endfunction

  // Two-flop synchronizer for the asynchronous key lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      ks_q    <= '0;
    end else begin
      sync1_q <= key;
      ks_q    <= sync1_q;
    end
  end

  always_comb begin
    any_c     = (ks_q != '0);
    one_hot_c = any_c && ((ks_q & (ks_q - KEY_W'(1))) == '0);
    multi_c   = any_c && !one_hot_c;
    dbc_inc_c = dbc_q + DB_W'(1);
    db_done_c = (dbc_inc_c >= DB_W'(DB_CYCLES));
    code_c    = enc(oh_q);
  end

  always_comb begin
    state_d     = state_q;
    oh_d        = oh_q;
    dbc_d       = dbc_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    digit_d     = digit_q;
    digit_vld_d = 1'b0;
    num_vld_d   = num_vld_q;
    err_d       = 1'b0;

    if (clr) begin
      num_d     = '0;
      cnt_d     = '0;
      num_vld_d = 1'b0;
      state_d   = any_c ? S_HELD : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (one_hot_c) begin
            oh_d    = ks_q;
            dbc_d   = DB_W'(1);
            state_d = S_PRESS_DB;
          end else if (multi_c) begin
            err_d   = 1'b1;
            state_d = S_HELD;
          end else if (enter && (cnt_q != '0)) begin
            num_vld_d = 1'b1;
            state_d   = S_OUT;
          end
        end
        S_PRESS_DB: begin
          if (ks_q == oh_q) begin
            dbc_d = dbc_inc_c;
            if (db_done_c) begin
              digit_d     = code_c;
              digit_vld_d = 1'b1;
              // A fifth digit is reported but never shifted in
              if (cnt_q < CNT_W'(4)) begin
                num_d = {num_q[NUM_W-CODE_W-1:0], code_c};
                cnt_d = cnt_q + CNT_W'(1);
              end else begin
                err_d = 1'b1;
              end
              state_d = S_HELD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HELD: begin
          if (!any_c) begin
            dbc_d   = DB_W'(1);
            state_d = S_REL_DB;
          end
        end
        S_REL_DB: begin
          if (any_c) begin
            state_d = S_HELD;
          end else begin
            dbc_d = dbc_inc_c;
            if (db_done_c) state_d = S_IDLE;
          end
        end
        S_OUT: begin
          if (num_vld_q && num_rdy) begin
            num_d     = '0;
            cnt_d     = '0;
            num_vld_d = 1'b0;
            state_d   = any_c ? S_HELD : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      oh_q        <= '0;
      dbc_q       <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      digit_q     <= '0;
      digit_vld_q <= 1'b0;
      num_vld_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      oh_q        <= oh_d;
      dbc_q       <= dbc_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      digit_vld_q <= digit_vld_d;
      num_vld_q   <= num_vld_d;
      err_q       <= err_d;
    end
  end

  assign num       = num_q;
  assign cnt       = cnt_q;
  assign digit     = digit_q;
  assign digit_vld = digit_vld_q;
  assign num_vld   = num_vld_q;
  assign err       = err_q;

endmodule
